// File: rtl/uart_debug_unit.sv
// rtl/uart_debug_unit.sv - host command controller between the UART FIFOs and the core
//
// Pops ASCII command bytes from the UART RX FIFO and gates the core's
// advance enable. It can run, single-step or halt the core, and it reports
// the core's PC+1 to the host as two bytes (high, then low) via the TX FIFO.
//
// Ports:
//   clk        system clock, shared with the UART and the core
//   reset      asynchronous, active-high reset
//   r_data     head byte of the RX FIFO, valid while rx_empty is low
//   rx_empty   RX FIFO empty flag
//   rd         RX FIFO pop strobe, one cycle per byte
//   w_data     byte pushed into the TX FIFO (0x00 when not sending)
//   wr         TX FIFO push strobe, one cycle per byte
//   tx_full    TX FIFO full flag
//   PC_plus_1  current PC+1 from the core
//   enable     core advance enable (registered)
module uart_debug_unit #(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          r_data,
  input  logic                rx_empty,
  output logic                rd,
  output logic [7:0]          w_data,
  output logic                wr,
  input  logic                tx_full,
  input  logic [PC_WIDTH-1:0] PC_plus_1,
  output logic                enable
);

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_PC   = 8'h70;  // 'p'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    SNAP    = 3'd3,
    SEND_HI = 3'd4,
    SEND_LO = 3'd5
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [PC_WIDTH-1:0] snapshot;
  logic [15:0]         snap_ext;

  // Zero-extend so the high byte is well defined for any width 9..16.
  assign snap_ext = 16'(snapshot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // enable is registered from next_state so it is high exactly while the
  // state register holds RUN or STEP, and reset clears it asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
      enable   <= 1'b0;
    end else begin
      if (state == SNAP) begin
        snapshot <= PC_plus_1;
      end
      enable <= (next_state == RUN) || (next_state == STEP);
    end
  end

  always_comb begin
    next_state = state;
    rd         = 1'b0;
    wr         = 1'b0;
    w_data     = 8'h00;
    case (state)
      IDLE: begin
        if (!rx_empty) begin
          rd = 1'b1;
          case (r_data)
            CMD_RUN:          next_state = RUN;
            CMD_STEP:         next_state = STEP;
            CMD_PC, CMD_HALT: next_state = SNAP;
            default:          next_state = IDLE;
          endcase
        end
      end
      RUN: begin
        // Everything but halt is drained and discarded while running.
        if (!rx_empty) begin
          rd = 1'b1;
          if (r_data == CMD_HALT) begin
            next_state = SNAP;
          end
        end
      end
      STEP: next_state = SNAP;
      SNAP: next_state = SEND_HI;
      SEND_HI: begin
        w_data = snap_ext[15:8];
        if (!tx_full) begin
          wr         = 1'b1;
          next_state = SEND_LO;
        end
      end
      SEND_LO: begin
        w_data = snap_ext[7:0];
        if (!tx_full) begin
          wr         = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // The state is forced to IDLE by reset, but the strobes are
    // combinational and must not pop or push while reset is held.
    if (reset) begin
      rd = 1'b0;
      wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_debug_unit.sv
// tb/tb_uart_debug_unit.sv - self-checking bench for uart_debug_unit
module tb_uart_debug_unit;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    r_data;
  logic          rx_empty;
  logic          rd;
  logic [7:0]    w_data;
  logic          wr;
  logic          tx_full;
  logic [PW-1:0] pc;
  logic          enable;

  always #5 clk = ~clk;

  uart_debug_unit #(.PC_WIDTH(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rd        (rd),
    .w_data    (w_data),
    .wr        (wr),
    .tx_full   (tx_full),
    .PC_plus_1 (pc),
    .enable    (enable)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         en_cycles = 0;
  int         pops = 0;
  logic       rd_s = 1'b0;
  logic       en_s = 1'b0;

  typedef struct {
    logic [7:0]    cmd;
    logic [PW-1:0] pc0;
    int            nb;
    logic [7:0]    hi;
    logic [7:0]    lo;
    int            en;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic upd_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
  endtask

  // Mid-cycle observation of the FIFO strobes and the core enable.
  task automatic sample();
    rd_s = rd;
    en_s = enable;
    if (wr) begin
      txq.push_back(w_data);
      chk("wr_while_full", int'(tx_full), 0);
    end
    if (enable) en_cycles++;
    if (rd) pops++;
    chk("enable_with_wr", int'(enable & wr), 0);
  endtask

  // Effects of the clock edge: FIFO pop and core PC advance.
  task automatic advance();
    if (rd_s) begin
      void'(rxq.pop_front());
      upd_rx();
    end
    if (en_s) pc = pc + 1'b1;
  endtask

  always @(negedge clk) sample();
  always @(posedge clk) begin
    #1;
    advance();
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic nxtn(input int n);
    repeat (n) nxt();
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    upd_rx();
  endtask

  task automatic clr();
    txq.delete();
    en_cycles = 0;
    pops = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int            hi_cnt;
    int            nsent;
    int            nsteps;
    int            done;
    logic [PW-1:0] pc_exp;
    logic [15:0]   expq[$];
    logic [7:0]    b;

    vecs[0] = '{8'h70, 10'h155, 2, 8'h01, 8'h55, 0};
    vecs[1] = '{8'h68, 10'h3FF, 2, 8'h03, 8'hFF, 0};
    vecs[2] = '{8'h73, 10'h010, 2, 8'h00, 8'h11, 1};
    vecs[3] = '{8'h73, 10'h0FF, 2, 8'h01, 8'h00, 1};
    vecs[4] = '{8'h73, 10'h3FF, 2, 8'h00, 8'h00, 1};
    vecs[5] = '{8'h41, 10'h123, 0, 8'h00, 8'h00, 0};
    vecs[6] = '{8'h00, 10'h123, 0, 8'h00, 8'h00, 0};
    vecs[7] = '{8'h50, 10'h123, 0, 8'h00, 8'h00, 0};

    // Reset with a pending 'p', then report PC.
    reset = 1'b1;
    tx_full = 1'b0;
    pc = 10'h2A5;
    upd_rx();
    push(8'h70);
    nxtn(2);
    chk("reset_rd", int'(rd), 0);
    chk("reset_wr", int'(wr), 0);
    chk("reset_w_data", int'(w_data), 0);
    chk("reset_enable", int'(enable), 0);
    reset = 1'b0;
    #1;
    chk("first_pop_rd", int'(rd), 1);
    nxt();
    chk("snap_wr", int'(wr), 0);
    chk("snap_rx_popped", rxq.size(), 0);
    nxt();
    chk("hi_wr", int'(wr), 1);
    chk("hi_data", int'(w_data), 8'h02);
    nxt();
    chk("lo_wr", int'(wr), 1);
    chk("lo_data", int'(w_data), 8'hA5);
    nxt();
    chk("idle_wr", int'(wr), 0);
    chk("idle_w_data", int'(w_data), 0);
    chk("report_enable_cycles", en_cycles, 0);
    chk("report_bytes", txq.size(), 2);

    // Single commands from IDLE.
    for (int i = 0; i < 8; i++) begin
      pc = vecs[i].pc0;
      clr();
      push(vecs[i].cmd);
      nxtn(8);
      chk("tbl_nbytes", txq.size(), vecs[i].nb);
      if (vecs[i].nb == 2 && txq.size() == 2) begin
        chk("tbl_hi", int'(txq[0]), int'(vecs[i].hi));
        chk("tbl_lo", int'(txq[1]), int'(vecs[i].lo));
      end
      chk("tbl_enable_cycles", en_cycles, vecs[i].en);
      chk("tbl_pops", pops, 1);
    end

    // Run, stray byte, halt.
    pc = 10'h100;
    clr();
    hi_cnt = 0;
    push(8'h63);
    for (int k = 1; k <= 30; k++) begin
      nxt();
      if (enable) hi_cnt++;
      if (k == 21) chk("run_stray_popped", rxq.size(), 0);
      if (k == 20) push(8'h78);
      if (k == 30) push(8'h68);
    end
    chk("run_enable_held", hi_cnt, 30);
    nxt();
    chk("halt_enable_off", int'(enable), 0);
    nxtn(3);
    chk("halt_nbytes", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("halt_hi", int'(txq[0]), 8'h01);
      chk("halt_lo", int'(txq[1]), 8'h1E);
    end
    chk("halt_enable_cycles", en_cycles, 30);
    chk("halt_pops", pops, 3);

    // TX full stall with a byte arriving mid-send.
    pc = 10'h2A5;
    clr();
    tx_full = 1'b1;
    push(8'h70);
    nxt();
    chk("stall_snap_wr", int'(wr), 0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("stall_wr", int'(wr), 0);
      chk("stall_w_data", int'(w_data), 8'h02);
      chk("stall_enable", int'(enable), 0);
      if (k == 1) push(8'h41);
      if (k == 4) chk("stall_rx_held", rxq.size(), 1);
    end
    tx_full = 1'b0;
    #1;
    chk("unstall_hi_wr", int'(wr), 1);
    nxt();
    chk("unstall_lo_wr", int'(wr), 1);
    chk("unstall_lo_data", int'(w_data), 8'hA5);
    nxtn(2);
    chk("stall_nbytes", txq.size(), 2);
    chk("stall_pops", pops, 2);
    chk("stall_rx_drained", rxq.size(), 0);

    // Three queued bytes popped back to back, then report.
    pc = 10'h0AB;
    clr();
    push(8'h41);
    push(8'h42);
    push(8'h70);
    nxt();
    chk("queue_pop1", rxq.size(), 2);
    nxt();
    chk("queue_pop2", rxq.size(), 1);
    nxt();
    chk("queue_pop3", rxq.size(), 0);
    nxtn(3);
    chk("queue_nbytes", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("queue_hi", int'(txq[0]), 8'h00);
      chk("queue_lo", int'(txq[1]), 8'hAB);
    end

    // Reset while running.
    clr();
    push(8'h63);
    nxtn(3);
    chk("pre_reset_run_enable", int'(enable), 1);
    push(8'h78);
    reset = 1'b1;
    #1;
    chk("run_reset_enable", int'(enable), 0);
    chk("run_reset_rd", int'(rd), 0);
    chk("run_reset_wr", int'(wr), 0);
    nxt();
    reset = 1'b0;
    nxtn(3);
    chk("run_reset_rx_drained", rxq.size(), 0);
    chk("run_reset_idle_enable", int'(enable), 0);
    chk("run_reset_nbytes", txq.size(), 0);

    // Reset during SEND_LO abandons the low byte.
    pc = 10'h2A5;
    clr();
    push(8'h70);
    nxtn(3);
    chk("pre_reset_lo_wr", int'(wr), 1);
    reset = 1'b1;
    #1;
    chk("lo_reset_wr", int'(wr), 0);
    chk("lo_reset_w_data", int'(w_data), 0);
    nxt();
    reset = 1'b0;
    nxtn(4);
    chk("lo_reset_nbytes", txq.size(), 1);
    push(8'h70);
    nxtn(6);
    chk("post_reset_nbytes", txq.size(), 3);
    if (txq.size() == 3) begin
      chk("post_reset_hi", int'(txq[1]), 8'h02);
      chk("post_reset_lo", int'(txq[2]), 8'hA5);
    end

    // Random command bursts with random TX back-pressure.
    clr();
    expq.delete();
    pc_exp = pc;
    nsent = 0;
    nsteps = 0;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        case ($urandom_range(0, 5))
          0: b = 8'h73;
          1: b = 8'h70;
          2: b = 8'h68;
          3: b = 8'h78;
          4: b = 8'h41;
          default: b = 8'($urandom_range(0, 255));
        endcase
        if (b == 8'h63) b = 8'h78;
        if (b == 8'h73) begin
          pc_exp = pc_exp + 1'b1;
          nsteps++;
          expq.push_back(16'(pc_exp));
        end else if (b == 8'h70 || b == 8'h68) begin
          expq.push_back(16'(pc_exp));
        end
        push(b);
        nsent++;
      end
      repeat ($urandom_range(0, 10)) begin
        tx_full = 1'($urandom_range(0, 1));
        nxt();
      end
    end
    tx_full = 1'b0;
    done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rxq.size() == 0 && txq.size() == 2 * expq.size()) begin
        done = 1;
        break;
      end
      nxt();
    end
    nxtn(8);
    chk("rand_drain_in_time", done, 1);
    chk("rand_nbytes", txq.size(), 2 * expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (2 * i + 1 < txq.size()) begin
        chk("rand_report", int'({txq[2*i], txq[2*i+1]}), int'(expq[i]));
      end
    end
    chk("rand_enable_cycles", en_cycles, nsteps);
    chk("rand_pops", pops, nsent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
